gcd_requester: RTL and testbench
================================

Name: gcd_requester

Overview:
- Initiator-side sequencer for the subtractive GCD engine (start/data_in/done interface).
- Accepts an operand pair on a valid/ready request channel and drives the engine's serial load protocol: start with operand A, then operand B on the next cycle.
- Waits for the engine's done, captures the result, clears the engine and returns the result on a valid/ready response channel.
- Short-circuits zero operands, which would never terminate in the subtractive engine.

Parameters:
- WIDTH, 16, operand/result width (matches engine data_in).
- TIMEOUT_CYC, 65535, max WAIT cycles before abort (used only with GCD_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  requester can accept a pair.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_gcd  out  WIDTH  GCD result.
- rsp_err  out  1  result aborted by timeout (tied 0 without GCD_TIMEOUT_EN).
- eng_start  out  1  engine start strobe.
- eng_data  out  WIDTH  engine data_in bus.
- eng_clr  out  1  one-cycle engine return-to-idle pulse.
- eng_done  in  1  engine done, level, sticky until eng_clr.
- eng_result  in  WIDTH  engine A-register value, valid while eng_done=1.

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_gcd=0, rsp_err=0, eng_start=0, eng_data=0, eng_clr=0. All outputs are registered.
- States: IDLE, SEND_A, SEND_B, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch a and b.
  - If a==0 or b==0: rsp_gcd<=a|b (gcd(x,0)=x, gcd(0,0)=0), go to RESP. No engine activity.
  - Otherwise go to SEND_A.
- SEND_A: eng_start=1, eng_data=a for exactly one cycle; go to SEND_B.
- SEND_B: eng_start=0, eng_data=b for exactly one cycle; go to WAIT.
- WAIT:
  - eng_data holds b.
  - When eng_done=1: rsp_gcd<=eng_result, eng_clr=1 for one cycle, go to RESP.
  - eng_done is ignored in every state except WAIT.
- RESP:
  - rsp_valid=1. rsp_gcd and rsp_err are stable until handshake.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
- req_ready=0 in every state except IDLE. No pipelining: one transaction in flight.
- Latency, nonzero operands: first eng_start 1 cycle after request accept; rsp_valid 1 cycle after the eng_done sample.
- Latency, zero operand: rsp_valid 1 cycle after accept.
- Back-to-back: a request accepted in the IDLE cycle immediately following the RESP handshake is legal.
- Reset mid-operation: immediately IDLE, any in-flight result is discarded, and eng_clr is not pulsed. The system reset also resets the engine.
- Result is never a subtraction remainder; the width is unchanged (WIDTH in, WIDTH out).

Optional Feature:
- Macro GCD_TIMEOUT_EN.
- Defined:
  - A WIDTH-independent 16-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with eng_done=0: rsp_gcd<=0, rsp_err<=1, eng_clr pulse, go to RESP.
  - rsp_err clears on the RESP handshake.
  - eng_done and the timeout in the same cycle: eng_done wins.
- Undefined: no counter; rsp_err tied 0; WAIT is unbounded.

Decomposition:
- Shared package gcd_pkg: state enum (IDLE, SEND_A, SEND_B, WAIT, RESP, 3-bit encoding), default WIDTH=16, default TIMEOUT_CYC.
- One sub-module is natural: gcd_req_timer (loadable down/up counter with clear/enable/expired), instantiated only under GCD_TIMEOUT_EN.

Test Plan:
- Request a=48, b=18 with engine model: eng_start=1/eng_data=48 at accept+1, eng_data=18 at accept+2; model asserts eng_done with result 6 → rsp_gcd=6, rsp_err=0, exactly one eng_clr pulse.
- Request a=0, b=35 → rsp_valid after 1 cycle, rsp_gcd=35, eng_start never asserted. Request a=0, b=0 → rsp_gcd=0.
- Backpressure: result 7 with rsp_ready held low 10 cycles → rsp_valid and rsp_gcd=7 held stable, req_ready=0 throughout. After release, the next request is accepted in the following cycle.
- Assert rst during WAIT, then assert eng_done → outputs return to reset values asynchronously, no rsp_valid, and the first post-reset request is processed normally.
- GCD_TIMEOUT_EN with TIMEOUT_CYC=20 and engine never done → rsp_valid at WAIT entry+20 with rsp_err=1, rsp_gcd=0, eng_clr pulsed once. eng_done asserted at cycle 20 → normal result, rsp_err=0.
- Five back-to-back random nonzero pairs (e.g. 1071/462→21, 65535/255→255) → results match the reference gcd, in order, with no dropped or duplicated responses.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine requester.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH       = 16;
    localparam int unsigned GCD_TIMEOUT_CYC = 65535;
    localparam int unsigned GCD_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } gcd_state_t;

endpackage

// File: rtl/gcd_req_timer.sv
// WAIT-state watchdog: 16-bit up counter with clear/enable, flags the LIMIT-th enabled cycle.
module gcd_req_timer
    import gcd_pkg::*;
#(
    parameter int unsigned LIMIT = GCD_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [GCD_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + GCD_CNT_W'(1);
        end
    end

    // count holds the number of completed enabled cycles, so LIMIT-1 marks the LIMIT-th one
    assign expired_c = en && (count == GCD_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/gcd_requester.sv
// Initiator-side sequencer for the subtractive GCD engine; optional WAIT watchdog under GCD_TIMEOUT_EN.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH
`ifdef GCD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = GCD_TIMEOUT_CYC
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_data,
    output logic             eng_clr,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result
);

    gcd_state_t       state, state_next;
    logic [WIDTH-1:0] b_q, b_next;
    logic [WIDTH-1:0] gcd_next, data_next;
    logic             valid_next, err_next, start_next, clr_next;
    logic             timeout_hit;

`ifdef GCD_TIMEOUT_EN
    logic tmr_expired_c;

    gcd_req_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == SEND_B),
        .en       (state == WAIT),
        .expired_c(tmr_expired_c)
    );

    assign timeout_hit = (state == WAIT) && tmr_expired_c;
`else
    assign timeout_hit = 1'b0;
`endif

    // Outputs are registered from next-state decode so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            b_q       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
            eng_data  <= '0;
            eng_clr   <= 1'b0;
        end else begin
            state     <= state_next;
            b_q       <= b_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= valid_next;
            rsp_gcd   <= gcd_next;
            rsp_err   <= err_next;
            eng_start <= start_next;
            eng_data  <= data_next;
            eng_clr   <= clr_next;
        end
    end

    always_comb begin
        state_next = state;
        b_next     = b_q;
        gcd_next   = rsp_gcd;
        err_next   = rsp_err;
        valid_next = 1'b0;
        start_next = 1'b0;
        clr_next   = 1'b0;
        data_next  = '0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    b_next = req_b;
                    // A zero operand would never terminate in the subtractive engine
                    if ((req_a == '0) || (req_b == '0)) begin
                        gcd_next   = req_a | req_b;
                        err_next   = 1'b0;
                        valid_next = 1'b1;
                        state_next = RESP;
                    end else begin
                        start_next = 1'b1;
                        data_next  = req_a;
                        state_next = SEND_A;
                    end
                end
            end
            SEND_A: begin
                data_next  = b_q;
                state_next = SEND_B;
            end
            SEND_B: begin
                data_next  = b_q;
                state_next = WAIT;
            end
            WAIT: begin
                data_next = b_q;
                if (eng_done) begin
                    gcd_next   = eng_result;
                    err_next   = 1'b0;
                    clr_next   = 1'b1;
                    valid_next = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    gcd_next   = '0;
                    err_next   = 1'b1;
                    clr_next   = 1'b1;
                    valid_next = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_next   = 1'b0;
                    state_next = IDLE;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural GCD engine on the eng_* side.
module tb_gcd_requester;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         eng_start;
    logic [W-1:0] eng_data;
    logic         eng_clr;
    logic         eng_done;
    logic [W-1:0] eng_result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Engine model state
    int unsigned  n_start = 0;
    int unsigned  n_clr = 0;
    int unsigned  lat_cfg = 3;
    int unsigned  phase = 0;
    int unsigned  cnt = 0;
    bit           eng_hold = 1'b0;
    bit           force_done = 1'b0;
    logic [W-1:0] force_res = '0;
    logic         done_int = 1'b0;
    logic [W-1:0] res_int = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;

    assign eng_done   = done_int | force_done;
    assign eng_result = force_done ? force_res : res_int;

    always #5 clk = ~clk;

    gcd_requester #(
        .WIDTH(W)
`ifdef GCD_TIMEOUT_EN
        , .TIMEOUT_CYC(20)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_clr   (eng_clr),
        .eng_done  (eng_done),
        .eng_result(eng_result)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine: loads A with start, B on the next cycle, raises done after lat_cfg cycles, sticky until clr
    always @(negedge clk) begin
        if (rst) begin
            phase    = 0;
            done_int = 1'b0;
            res_int  = '0;
        end else begin
            if (eng_start) n_start++;
            if (eng_clr) begin
                n_clr++;
                done_int = 1'b0;
                phase    = 0;
            end
            case (phase)
                0: if (eng_start) begin
                    op_a  = eng_data;
                    phase = 1;
                end
                1: begin
                    op_b  = eng_data;
                    cnt   = lat_cfg;
                    phase = 2;
                end
                2: if (!eng_hold) begin
                    if (cnt <= 1) begin
                        done_int = 1'b1;
                        res_int  = ref_gcd(op_a, op_b);
                        phase    = 3;
                    end else begin
                        cnt--;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        chk("send.req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!rsp_valid && k < 500) begin
            tick();
            k++;
        end
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic get_rsp(input string tag, input logic [W-1:0] g, input logic e);
        wait_valid(tag);
        chk({tag, ".gcd"}, 32'(rsp_gcd), 32'(g));
        chk({tag, ".err"}, 32'(rsp_err), 32'(e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s_start, s_clr;
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vg [5];
        va = '{16'd1071, 16'd65535, 16'd270, 16'd17, 16'd4096};
        vb = '{16'd462,  16'd255,   16'd192, 16'd5,  16'd1024};
        vg = '{16'd21,   16'd255,   16'd6,   16'd1,  16'd1024};

        // Reset values
        tick();
        tick();
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_gcd",   32'(rsp_gcd),   32'd0);
        chk("rst.rsp_err",   32'(rsp_err),   32'd0);
        chk("rst.eng_start", 32'(eng_start), 32'd0);
        chk("rst.eng_data",  32'(eng_data),  32'd0);
        chk("rst.eng_clr",   32'(eng_clr),   32'd0);
        rst = 1'b0;
        tick();
        chk("idle.req_ready", 32'(req_ready), 32'd1);

        // 48/18 through the engine
        lat_cfg = 5;
        s_start = n_start;
        s_clr   = n_clr;
        send(16'd48, 16'd18);
        chk("g48.start_a", 32'(eng_start), 32'd1);
        chk("g48.data_a",  32'(eng_data),  32'd48);
        chk("g48.busy",    32'(req_ready), 32'd0);
        tick();
        chk("g48.start_b", 32'(eng_start), 32'd0);
        chk("g48.data_b",  32'(eng_data),  32'd18);
        tick();
        chk("g48.data_hold", 32'(eng_data), 32'd18);
        get_rsp("g48", 16'd6, 1'b0);
        chk("g48.n_start", n_start - s_start, 32'd1);
        chk("g48.n_clr",   n_clr - s_clr,     32'd1);

        // Zero operands bypass the engine
        s_start = n_start;
        s_clr   = n_clr;
        send(16'd0, 16'd35);
        chk("z35.lat1", 32'(rsp_valid), 32'd1);
        get_rsp("z35", 16'd35, 1'b0);
        send(16'd0, 16'd0);
        chk("z0.lat1", 32'(rsp_valid), 32'd1);
        get_rsp("z0", 16'd0, 1'b0);
        send(16'd40, 16'd0);
        get_rsp("z40", 16'd40, 1'b0);
        chk("zero.n_start", n_start - s_start, 32'd0);
        chk("zero.n_clr",   n_clr - s_clr,     32'd0);

        // Backpressure on the response channel, then immediate next request
        lat_cfg = 3;
        send(16'd21, 16'd14);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.gcd",   32'(rsp_gcd),   32'd7);
            chk("bp.rdy",   32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp.rdy_after", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = 16'd100;
        req_b     = 16'd75;
        tick();
        req_valid = 1'b0;
        chk("bp.next_start", 32'(eng_start), 32'd1);
        chk("bp.next_data",  32'(eng_data),  32'd100);
        get_rsp("g100", 16'd25, 1'b0);

        // Reset while waiting on the engine
        eng_hold = 1'b1;
        s_clr    = n_clr;
        send(16'd9, 16'd6);
        tick();
        tick();
        tick();
        chk("rw.data_pre", 32'(eng_data), 32'd6);
        #1 rst = 1'b1;
        #1;
        chk("rw.req_ready", 32'(req_ready), 32'd0);
        chk("rw.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw.eng_data",  32'(eng_data),  32'd0);
        chk("rw.eng_clr",   32'(eng_clr),   32'd0);
        force_res  = 16'd3;
        force_done = 1'b1;
        tick();
        tick();
        chk("rw.no_valid", 32'(rsp_valid), 32'd0);
        rst        = 1'b0;
        force_done = 1'b0;
        eng_hold   = 1'b0;
        tick();
        tick();
        chk("rw.no_valid_post", 32'(rsp_valid), 32'd0);
        chk("rw.no_clr",        n_clr - s_clr,  32'd0);
        send(16'd1071, 16'd462);
        get_rsp("rw.first", 16'd21, 1'b0);

        // Back-to-back pairs
        s_start = n_start;
        s_clr   = n_clr;
        for (int i = 0; i < 5; i++) begin
            lat_cfg = 2 + i;
            send(va[i], vb[i]);
            get_rsp("b2b", vg[i], 1'b0);
        end
        chk("b2b.n_start", n_start - s_start, 32'd5);
        chk("b2b.n_clr",   n_clr - s_clr,     32'd5);
        tick();
        tick();
        chk("b2b.quiet", 32'(rsp_valid), 32'd0);

`ifdef GCD_TIMEOUT_EN
        begin
            int k;
            // Engine never finishes: abort after 20 WAIT cycles
            eng_hold = 1'b1;
            s_clr    = n_clr;
            send(16'd10, 16'd4);
            tick();
            tick();
            k = 0;
            while (!rsp_valid && k < 40) begin
                tick();
                k++;
            end
            chk("to.cycles", 32'(k), 32'd20);
            get_rsp("to", 16'd0, 1'b1);
            chk("to.n_clr", n_clr - s_clr, 32'd1);

            // done in the final WAIT cycle beats the timeout
            send(16'd10, 16'd4);
            tick();
            tick();
            repeat (19) tick();
            chk("tod.early", 32'(rsp_valid), 32'd0);
            force_res  = 16'd2;
            force_done = 1'b1;
            tick();
            force_done = 1'b0;
            chk("tod.valid", 32'(rsp_valid), 32'd1);
            get_rsp("tod", 16'd2, 1'b0);
            eng_hold = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
